// File: rtl/bird_pkg.sv
// Shared types and the bird row decode used by bird_column and the LED matrix driver.
package bird_pkg;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_FLY  = 2'd1,
    B_DEAD = 2'd2
  } bird_state_e;

  localparam int unsigned MASK_W = 64;

  // Bit i set when a bird `height` rows tall with its bottom at `pos` covers row i.
  function automatic logic [MASK_W-1:0] bird_mask(input int unsigned pos,
                                                  input int unsigned height);
    logic [MASK_W-1:0] one;
    one = MASK_W'(1);
    return ((one << height) - one) << pos;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: tick is high for one clock every 2^WIDTH enabled clocks.
module tick_divider #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign tick = en && (r_cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/bird_column.sv
// Bird sprite controller for one LED column: gravity, tap-to-climb, floor/wall crash.
// Handshake: none; tap is a single-cycle pulse, restart a synchronous pulse, startGame a level.
module bird_column
  import bird_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int BIRD_H    = 2,
  parameter int START_ROW = 3,
  parameter int JUMP      = 1,
  parameter int TICK_W    = 8,
  localparam int PW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startGame,
  input  logic            restart,
  input  logic            tap,
  input  logic [ROWS-1:0] wall,
  output logic [ROWS-1:0] rows,
  output logic [PW-1:0]   pos,
  output logic            alive,
  output logic            crash,
  output bird_state_e     dbg_state
);

  localparam int MAX_POS = ROWS - BIRD_H;

  bird_state_e r_state, w_state_n;
  logic [PW-1:0] r_pos, w_pos_n;
  logic          r_tap_pend, w_tap_pend_n;
  logic          r_alive, r_crash, w_crash_n;
  logic          w_clear, w_en, w_tick;
  logic [ROWS-1:0] w_rows;
  logic          w_hit, w_tap_any;
  logic [PW:0]   w_up;

  tick_divider #(.WIDTH(TICK_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (w_en),
    .tick  (w_tick)
  );

  assign w_rows    = ROWS'(bird_mask(32'(r_pos), 32'(BIRD_H)));
  assign w_hit     = |(w_rows & wall);
  assign w_tap_any = r_tap_pend | tap;
  assign w_en      = (r_state == B_FLY);
  // One bit wider so the climb can be clamped at the ceiling without wrapping.
  assign w_up      = {1'b0, r_pos} + (PW+1)'(JUMP);

  always_comb begin
    w_state_n    = r_state;
    w_pos_n      = r_pos;
    w_tap_pend_n = r_tap_pend;
    w_crash_n    = 1'b0;
    w_clear      = 1'b0;
    if (restart) begin
      w_state_n    = B_IDLE;
      w_pos_n      = PW'(START_ROW);
      w_tap_pend_n = 1'b0;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        B_IDLE: begin
          w_pos_n      = PW'(START_ROW);
          w_tap_pend_n = 1'b0;
          w_clear      = 1'b1;
          if (startGame) w_state_n = B_FLY;
        end
        B_FLY: begin
          // A wall hit freezes the bird even if a tick would have moved it.
          if (w_hit) begin
            w_state_n = B_DEAD;
            w_crash_n = 1'b1;
          end else if (w_tick) begin
            w_tap_pend_n = 1'b0;
            if (w_tap_any) begin
              w_pos_n = (w_up > (PW+1)'(MAX_POS)) ? PW'(MAX_POS) : w_up[PW-1:0];
            end else if (r_pos != '0) begin
              w_pos_n = r_pos - PW'(1);
            end else begin
              w_state_n = B_DEAD;
              w_crash_n = 1'b1;
            end
          end else if (tap) begin
            w_tap_pend_n = 1'b1;
          end
        end
        B_DEAD: ;
        default: w_state_n = B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= B_IDLE;
      r_pos      <= PW'(START_ROW);
      r_tap_pend <= 1'b0;
      r_alive    <= 1'b0;
      r_crash    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pos      <= w_pos_n;
      r_tap_pend <= w_tap_pend_n;
      r_alive    <= (w_state_n == B_FLY);
      r_crash    <= w_crash_n;
    end
  end

  assign rows      = w_rows;
  assign pos       = r_pos;
  assign alive     = r_alive;
  assign crash     = r_crash;
  assign dbg_state = r_state;

endmodule
